spi_master_cs: RTL and testbench

//  Parametrised SPI master: DataWidth-bit words, per-word SPI mode 0-3, MSB/LSB-first order,

---
 rtl/spi_master_cs.sv | 177 +++++++++++++++++
 tb/tb_spi_master_cs.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cs.sv
// SPI master with per-word mode/bit order, programmable SCLK divider and NumCs active-low chip selects.
// Optional feature: define SPI_LOOPBACK_EN to add i_cfg_loopback (sample o_mosi instead of i_miso).
module spi_master_cs #(
    parameter int DataWidth = 8,
    parameter int NumCs     = 1,
    parameter int DivWidth  = 8,
    localparam int CsSelW   = (NumCs > 1) ? $clog2(NumCs) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_sclk,
    output logic                 o_mosi,
    input  logic                 i_miso,
    output logic [NumCs-1:0]     o_cs_n,
    input  logic                 i_din_valid,
    output logic                 o_din_ready,
    input  logic [DataWidth-1:0] i_din_bits,
    output logic                 o_dout_valid,
    input  logic                 i_dout_ready,
    output logic [DataWidth-1:0] o_dout_bits,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [DivWidth-1:0]  i_cfg_div,
    input  logic [1:0]           i_cfg_mode,
    input  logic                 i_cfg_lsb,
    input  logic [CsSelW-1:0]    i_cfg_cs_sel,
    input  logic                 i_cfg_cs_hold,
`ifdef SPI_LOOPBACK_EN
    input  logic                 i_cfg_loopback,
`endif
    output logic                 o_busy
);
    localparam int CntW = $clog2(DataWidth + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, TAIL} state_t;

    state_t                state;
    logic [DivWidth:0]     half_cnt;
    logic [CntW-1:0]       bit_cnt;
    logic [DataWidth-1:0]  tx_sh;
    logic [DataWidth-1:0]  rx_sh;
    logic [DivWidth-1:0]   cfg_div;
    logic [1:0]            cfg_mode;
    logic                  cfg_lsb;
    logic [CsSelW-1:0]     cfg_sel;
    logic                  cfg_hold;
`ifdef SPI_LOOPBACK_EN
    logic                  cfg_lb;
`endif

    logic                  cfg_fire, din_fire, dout_fire;
    logic                  half_done, leading, sample_now, shift_now, last_edge;
    logic                  miso_bit, tx_head, din_head;
    logic [CntW-1:0]       cnt_after;
    logic [DataWidth-1:0]  tx_shifted, din_shifted, rx_next;
    logic [NumCs-1:0]      cs_sel_n;

    assign o_cfg_ready = (state == IDLE);
    assign o_din_ready = (state == IDLE) && !o_dout_valid && !i_cfg_valid;
    assign cfg_fire    = i_cfg_valid && o_cfg_ready;
    assign din_fire    = i_din_valid && o_din_ready;
    assign dout_fire   = o_dout_valid && i_dout_ready;

`ifdef SPI_LOOPBACK_EN
    assign miso_bit = cfg_lb ? o_mosi : i_miso;
`else
    assign miso_bit = i_miso;
`endif

    // An edge is leading when SCLK currently rests at CPOL; CPHA picks which edge samples.
    assign half_done  = (half_cnt == {1'b0, cfg_div});
    assign leading    = (o_sclk == cfg_mode[1]);
    assign sample_now = (leading != cfg_mode[0]);
    assign shift_now  = !sample_now;
    assign cnt_after  = sample_now ? bit_cnt - 1'b1 : bit_cnt;
    assign last_edge  = !leading && (cnt_after == '0);

    assign tx_head     = cfg_lsb ? tx_sh[0] : tx_sh[DataWidth-1];
    assign tx_shifted  = cfg_lsb ? {1'b0, tx_sh[DataWidth-1:1]} : {tx_sh[DataWidth-2:0], 1'b0};
    assign din_head    = cfg_lsb ? i_din_bits[0] : i_din_bits[DataWidth-1];
    assign din_shifted = cfg_lsb ? {1'b0, i_din_bits[DataWidth-1:1]}
                                 : {i_din_bits[DataWidth-2:0], 1'b0};
    assign rx_next     = cfg_lsb ? {miso_bit, rx_sh[DataWidth-1:1]} : {rx_sh[DataWidth-2:0], miso_bit};

    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NumCs; i++) begin
            if (CsSelW'(i) == cfg_sel) cs_sel_n[i] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            o_sclk       <= 1'b0;
            o_mosi       <= 1'b0;
            o_cs_n       <= '1;
            o_dout_valid <= 1'b0;
            o_dout_bits  <= '0;
            o_busy       <= 1'b0;
            cfg_div      <= '0;
            cfg_mode     <= '0;
            cfg_lsb      <= 1'b0;
            cfg_sel      <= '0;
            cfg_hold     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            cfg_lb       <= 1'b0;
`endif
        end else begin
            if (dout_fire) o_dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        cfg_div  <= i_cfg_div;
                        cfg_mode <= i_cfg_mode;
                        cfg_lsb  <= i_cfg_lsb;
                        cfg_sel  <= i_cfg_cs_sel;
                        cfg_hold <= i_cfg_cs_hold;
`ifdef SPI_LOOPBACK_EN
                        cfg_lb   <= i_cfg_loopback;
`endif
                        o_sclk   <= i_cfg_mode[1];
                        o_cs_n   <= '1;
                    end else if (din_fire) begin
                        state    <= SETUP;
                        half_cnt <= '0;
                        bit_cnt  <= CntW'(DataWidth);
                        rx_sh    <= '0;
                        o_busy   <= 1'b1;
                        o_cs_n   <= cs_sel_n;
                        // With CPHA=0 the first bit must be on MOSI before the first (sampling) edge.
                        if (!cfg_mode[0]) begin
                            o_mosi <= din_head;
                            tx_sh  <= din_shifted;
                        end else begin
                            tx_sh  <= i_din_bits;
                        end
                    end
                end
                SETUP, XFER: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        o_sclk   <= ~o_sclk;
                        if (sample_now) begin
                            rx_sh   <= rx_next;
                            bit_cnt <= cnt_after;
                        end
                        if (shift_now && (bit_cnt != '0)) begin
                            o_mosi <= tx_head;
                            tx_sh  <= tx_shifted;
                        end
                        state <= last_edge ? TAIL : XFER;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                TAIL: begin
                    if (half_done) begin
                        half_cnt     <= '0;
                        state        <= IDLE;
                        o_busy       <= 1'b0;
                        o_dout_valid <= 1'b1;
                        o_dout_bits  <= rx_sh;
                        if (!cfg_hold) o_cs_n <= '1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_cs.sv
// Directed self-checking bench for spi_master_cs (DataWidth=8, NumCs=4).
// Exercises mode 0/3, LSB order, CS hold, RX back-pressure, mid-transfer reset and cfg priority.
module tb_spi_master_cs;
    localparam int DW   = 8;
    localparam int NC   = 4;
    localparam int DIVW = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            o_sclk, o_mosi, i_miso;
    logic [NC-1:0]   o_cs_n;
    logic            i_din_valid, o_din_ready;
    logic [DW-1:0]   i_din_bits;
    logic            o_dout_valid, i_dout_ready;
    logic [DW-1:0]   o_dout_bits;
    logic            i_cfg_valid, o_cfg_ready;
    logic [DIVW-1:0] i_cfg_div;
    logic [1:0]      i_cfg_mode;
    logic            i_cfg_lsb;
    logic [1:0]      i_cfg_cs_sel;
    logic            i_cfg_cs_hold;
`ifdef SPI_LOOPBACK_EN
    logic            i_cfg_loopback = 1'b0;
`endif
    logic            o_busy;

    int checks = 0;
    int passed = 0;

    // MISO source: 0 = tied to MOSI, 1 = slave model, 2 = stuck at 0
    int          miso_mode = 0;
    logic        slave_bit = 1'b0;
    int          slave_idx = 0;
    logic [7:0]  slave_word = 8'h3C;
    logic        hold_watch = 1'b0;
    int          gap_cnt = 0;

    spi_master_cs #(.DataWidth(DW), .NumCs(NC), .DivWidth(DIVW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(i_miso), .o_cs_n(o_cs_n),
        .i_din_valid(i_din_valid), .o_din_ready(o_din_ready), .i_din_bits(i_din_bits),
        .o_dout_valid(o_dout_valid), .i_dout_ready(i_dout_ready), .o_dout_bits(o_dout_bits),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_div(i_cfg_div),
        .i_cfg_mode(i_cfg_mode), .i_cfg_lsb(i_cfg_lsb), .i_cfg_cs_sel(i_cfg_cs_sel),
        .i_cfg_cs_hold(i_cfg_cs_hold),
`ifdef SPI_LOOPBACK_EN
        .i_cfg_loopback(i_cfg_loopback),
`endif
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    assign i_miso = (miso_mode == 0) ? o_mosi : (miso_mode == 1) ? slave_bit : 1'b0;

    // Mode-3 slave: presents the next LSB-first bit on each falling (leading) edge.
    always @(o_sclk) begin
        if (miso_mode == 1 && o_sclk == 1'b0) begin
            slave_bit = slave_word[slave_idx[2:0]];
            slave_idx = slave_idx + 1;
        end
    end

    always @(negedge i_clk) begin
        if (hold_watch && o_cs_n[2]) gap_cnt = gap_cnt + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic apply_cfg(input logic [7:0] div, input logic [1:0] mode, input logic lsb,
                             input logic [1:0] sel, input logic hold);
        i_cfg_div = div; i_cfg_mode = mode; i_cfg_lsb = lsb;
        i_cfg_cs_sel = sel; i_cfg_cs_hold = hold;
        i_cfg_valid = 1'b1;
        @(posedge i_clk); #1;
        i_cfg_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [7:0] w);
        int n = 0;
        while (!o_din_ready && n < 200) begin
            @(posedge i_clk); #1; n++;
        end
        check_output("din_ready_wait", {31'd0, o_din_ready}, 32'd1);
        i_din_bits  = w;
        i_din_valid = 1'b1;
        @(posedge i_clk); #1;
        i_din_valid = 1'b0;
    endtask

    task automatic wait_dout(input int limit, input logic cap_level, output int cycles,
                             output int edges, output int cs_low, output logic [7:0] cap);
        logic prev;
        prev   = o_sclk;
        cycles = 1;
        edges  = 0;
        cap    = 8'h00;
        cs_low = (o_cs_n != '1) ? 1 : 0;
        while (!o_dout_valid && cycles < limit) begin
            @(posedge i_clk); #1;
            cycles++;
            if (o_sclk != prev) begin
                edges++;
                if (o_sclk == cap_level) cap = {o_mosi, cap[7:1]};
            end
            prev = o_sclk;
            if (o_cs_n != '1) cs_low++;
        end
        check_output("dout_seen", {31'd0, o_dout_valid}, 32'd1);
    endtask

    task automatic accept_dout();
        i_dout_ready = 1'b1;
        @(posedge i_clk); #1;
        i_dout_ready = 1'b0;
        check_output("dout_clear", {31'd0, o_dout_valid}, 32'd0);
    endtask

    initial begin
        int cyc, edg, csl, rdy_cnt, n, vcnt;
        logic [7:0] cap;
        logic prev;
        logic [7:0] words [3];
        words = '{8'h11, 8'h22, 8'h33};

        i_rst = 1'b1; i_din_valid = 1'b0; i_din_bits = '0; i_dout_ready = 1'b0;
        i_cfg_valid = 1'b0; i_cfg_div = '0; i_cfg_mode = '0; i_cfg_lsb = 1'b0;
        i_cfg_cs_sel = '0; i_cfg_cs_hold = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        $display("[TB] reset state");
        check_output("rst_sclk", {31'd0, o_sclk}, 32'd0);
        check_output("rst_mosi", {31'd0, o_mosi}, 32'd0);
        check_output("rst_cs_n", {28'd0, o_cs_n}, 32'hF);
        check_output("rst_dout_valid", {31'd0, o_dout_valid}, 32'd0);
        check_output("rst_busy", {31'd0, o_busy}, 32'd0);
        check_output("rst_cfg_ready", {31'd0, o_cfg_ready}, 32'd1);
        check_output("rst_din_ready", {31'd0, o_din_ready}, 32'd1);

        $display("[TB] mode0 div0 loopback 0xA5");
        apply_stimulus(8'hA5);
        check_output("t1_busy", {31'd0, o_busy}, 32'd1);
        check_output("t1_cs_setup", {28'd0, o_cs_n}, 32'hE);
        check_output("t1_mosi_first", {31'd0, o_mosi}, 32'd1);
        wait_dout(200, 1'b1, cyc, edg, csl, cap);
        check_output("t1_latency", cyc, 32'd18);
        check_output("t1_edges", edg, 32'd16);
        check_output("t1_cs_low_cycles", csl, 32'd17);
        check_output("t1_dout", {24'd0, o_dout_bits}, 32'hA5);
        check_output("t1_cs_release", {28'd0, o_cs_n}, 32'hF);
        check_output("t1_busy_end", {31'd0, o_busy}, 32'd0);
        accept_dout();

        $display("[TB] mode3 div3 lsb-first slave 0x3C");
        apply_cfg(8'd3, 2'b11, 1'b1, 2'd0, 1'b0);
        check_output("t2_sclk_idle", {31'd0, o_sclk}, 32'd1);
        miso_mode = 1;
        apply_stimulus(8'hC6);
        check_output("t2_sclk_setup", {31'd0, o_sclk}, 32'd1);
        wait_dout(500, 1'b1, cyc, edg, csl, cap);
        check_output("t2_latency", cyc, 32'd69);
        check_output("t2_edges", edg, 32'd16);
        check_output("t2_cs_low_cycles", csl, 32'd68);
        check_output("t2_dout", {24'd0, o_dout_bits}, 32'h3C);
        check_output("t2_mosi_bits", {24'd0, cap}, 32'hC6);
        check_output("t2_sclk_end", {31'd0, o_sclk}, 32'd1);
        accept_dout();

        $display("[TB] cs hold on sel 2");
        miso_mode = 0;
        apply_cfg(8'd0, 2'b00, 1'b0, 2'd2, 1'b1);
        check_output("t3_cs_after_cfg", {28'd0, o_cs_n}, 32'hF);
        for (int w = 0; w < 3; w++) begin
            apply_stimulus(words[w]);
            hold_watch = 1'b1;
            check_output("t3_cs_asserted", {28'd0, o_cs_n}, 32'hB);
            wait_dout(200, 1'b1, cyc, edg, csl, cap);
            check_output("t3_dout", {24'd0, o_dout_bits}, {24'd0, words[w]});
            accept_dout();
        end
        check_output("t3_cs_still_held", {28'd0, o_cs_n}, 32'hB);
        hold_watch = 1'b0;
        check_output("t3_no_gap", gap_cnt, 32'd0);
        apply_cfg(8'd0, 2'b00, 1'b0, 2'd2, 1'b0);
        check_output("t3_cs_released", {28'd0, o_cs_n}, 32'hF);

        $display("[TB] rx back-pressure");
        apply_stimulus(8'h5C);
        wait_dout(200, 1'b1, cyc, edg, csl, cap);
        check_output("t4_dout_first", {24'd0, o_dout_bits}, 32'h5C);
        i_din_bits  = 8'h99;
        i_din_valid = 1'b1;
        rdy_cnt = 0;
        repeat (5) begin
            @(posedge i_clk); #1;
            if (o_din_ready) rdy_cnt++;
        end
        check_output("t4_din_blocked", rdy_cnt, 32'd0);
        check_output("t4_dout_kept", {24'd0, o_dout_bits}, 32'h5C);
        check_output("t4_not_started", {31'd0, o_busy}, 32'd0);
        i_dout_ready = 1'b1;
        @(posedge i_clk); #1;
        i_dout_ready = 1'b0;
        check_output("t4_dout_taken", {31'd0, o_dout_valid}, 32'd0);
        check_output("t4_din_ready_back", {31'd0, o_din_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_din_valid = 1'b0;
        check_output("t4_second_started", {31'd0, o_busy}, 32'd1);
        wait_dout(200, 1'b1, cyc, edg, csl, cap);
        check_output("t4_dout_second", {24'd0, o_dout_bits}, 32'h99);
        accept_dout();

        $display("[TB] reset mid-transfer");
        apply_stimulus(8'hF0);
        prev = o_sclk; edg = 0; n = 0;
        while (edg < 5 && n < 100) begin
            @(posedge i_clk); #1; n++;
            if (o_sclk != prev) edg++;
            prev = o_sclk;
        end
        check_output("t5_edges_reached", edg, 32'd5);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        check_output("t5_cs_n", {28'd0, o_cs_n}, 32'hF);
        check_output("t5_sclk", {31'd0, o_sclk}, 32'd0);
        check_output("t5_busy", {31'd0, o_busy}, 32'd0);
        check_output("t5_dout_valid", {31'd0, o_dout_valid}, 32'd0);
        i_rst = 1'b0;
        vcnt = 0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_dout_valid) vcnt++;
        end
        check_output("t5_no_partial_dout", vcnt, 32'd0);

        $display("[TB] cfg priority over din");
        i_cfg_div = 8'd0; i_cfg_mode = 2'b10; i_cfg_lsb = 1'b0;
        i_cfg_cs_sel = 2'd1; i_cfg_cs_hold = 1'b0;
        i_cfg_valid = 1'b1;
        i_din_bits  = 8'h77;
        i_din_valid = 1'b1;
        #1;
        check_output("t6_din_ready_low", {31'd0, o_din_ready}, 32'd0);
        check_output("t6_cfg_ready", {31'd0, o_cfg_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_cfg_valid = 1'b0;
        i_din_valid = 1'b0;
        check_output("t6_din_not_taken", {31'd0, o_busy}, 32'd0);
        check_output("t6_cpol_applied", {31'd0, o_sclk}, 32'd1);

        miso_mode = 2;
`ifdef SPI_LOOPBACK_EN
        i_cfg_loopback = 1'b1;
        apply_cfg(8'd0, 2'b00, 1'b0, 2'd0, 1'b0);
        apply_stimulus(8'h5A);
        wait_dout(200, 1'b1, cyc, edg, csl, cap);
        check_output("t6_loopback_dout", {24'd0, o_dout_bits}, 32'h5A);
`else
        apply_cfg(8'd0, 2'b00, 1'b0, 2'd0, 1'b0);
        apply_stimulus(8'h5A);
        wait_dout(200, 1'b1, cyc, edg, csl, cap);
        check_output("t6_miso_stuck_dout", {24'd0, o_dout_bits}, 32'h00);
`endif
        accept_dout();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
